// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised sync FIFO.
// Status-vector layout and default geometry live here.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    localparam int ST_FULL   = 0;
    localparam int ST_AFULL  = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_AEMPTY = 3;
    localparam int ST_OVF    = 4;
    localparam int ST_UDF    = 5;
    localparam int ST_W      = 6;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Contents are not reset.
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, sticky errors,
// synchronous flush and optional first-word-fall-through read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0,
    localparam int AW      = clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              almost_empty,
    output logic              underflow,
    output logic [CW-1:0]     fifo_words
);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of 2 >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync_param: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_param: AE_LEVEL out of range");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              ovf_q;
    logic              udf_q;
    logic [DATA_W-1:0] ram_rdata;
    logic [ST_W-1:0]   status;
    logic              rd_ok;
    logic              wr_ok;
    logic              mem_we;

    assign status[ST_FULL]   = (count == CW'(DEPTH));
    assign status[ST_AFULL]  = (count >= CW'(AF_LEVEL));
    assign status[ST_EMPTY]  = (count == '0);
    assign status[ST_AEMPTY] = (count <= CW'(AE_LEVEL));
    assign status[ST_OVF]    = ovf_q;
    assign status[ST_UDF]    = udf_q;

    assign full         = status[ST_FULL];
    assign almost_full  = status[ST_AFULL];
    assign empty        = status[ST_EMPTY];
    assign almost_empty = status[ST_AEMPTY];
    assign overflow     = status[ST_OVF];
    assign underflow    = status[ST_UDF];
    assign fifo_words   = count;

    // A write into a full FIFO is only taken when a pop frees the slot
    assign rd_ok  = rd_en & ~empty;
    assign wr_ok  = wr_en & (~full | rd_ok);
    assign mem_we = wr_ok & rst_n & ~clr;

    fifo_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_en && !wr_ok) ovf_q <= 1'b1;
            if (rd_en && !rd_ok) udf_q <= 1'b1;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is shown directly; zero while empty so reset reads 0
        always_comb begin
            data_out = empty ? '0 : ram_rdata;
        end
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;

        // Registered read: popped word appears the cycle after rd_ok
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (!clr && rd_ok) begin
                dout_q <= ram_rdata;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench: FWFT=0 and FWFT=1 instances share one stimulus.
// Expected values are hand-derived per step.
module tb_fifo_sync_param;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;

    logic       full0, afull0, ovf0, empty0, aempty0, udf0;
    logic [7:0] dout0;
    logic [3:0] words0;
    logic       full1, afull1, ovf1, empty1, aempty1, udf1;
    logic [7:0] dout1;
    logic [3:0] words1;

    int total = 0;
    int bad   = 0;

    fifo_sync_param #(
        .DATA_W(8), .DEPTH(8), .AF_LEVEL(6),
        .AE_LEVEL(2), .FWFT(1'b0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_en(wr_en), .data_in(data_in),
        .full(full0), .almost_full(afull0),
        .overflow(ovf0), .rd_en(rd_en),
        .data_out(dout0), .empty(empty0),
        .almost_empty(aempty0), .underflow(udf0),
        .fifo_words(words0)
    );

    fifo_sync_param #(
        .DATA_W(8), .DEPTH(8), .AF_LEVEL(6),
        .AE_LEVEL(2), .FWFT(1'b1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_en(wr_en), .data_in(data_in),
        .full(full1), .almost_full(afull1),
        .overflow(ovf1), .rd_en(rd_en),
        .data_out(dout1), .empty(empty1),
        .almost_empty(aempty1), .underflow(udf1),
        .fifo_words(words1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status common to both instances
    task automatic chk_st(input string tag,
                          input int n,
                          input logic ov,
                          input logic un);
        check({tag, ".w0"}, 32'(words0), 32'(n));
        check({tag, ".w1"}, 32'(words1), 32'(n));
        check({tag, ".f"}, 32'({full0, full1}),
              32'({2{n == 8}}));
        check({tag, ".af"}, 32'({afull0, afull1}),
              32'({2{n >= 6}}));
        check({tag, ".e"}, 32'({empty0, empty1}),
              32'({2{n == 0}}));
        check({tag, ".ae"}, 32'({aempty0, aempty1}),
              32'({2{n <= 2}}));
        check({tag, ".ov"}, 32'({ovf0, ovf1}),
              32'({2{ov}}));
        check({tag, ".un"}, 32'({udf0, udf1}),
              32'({2{un}}));
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        data_in = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop_chk(input string tag,
                           input logic [7:0] d);
        check({tag, ".fwft"}, 32'(dout1), 32'(d));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, ".std"}, 32'(dout0), 32'(d));
    endtask

    task automatic flush();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        tick();
        rst_n = 1'b1;
        chk_st("por", 0, 1'b0, 1'b0);

        // 1: reset mid-traffic
        push(8'h11);
        push(8'h22);
        pop_chk("pre", 8'h11);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 8'h99;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_st("rst", 0, 1'b0, 1'b0);
        check("rst.d0", 32'(dout0), 32'h0);
        check("rst.d1", 32'(dout1), 32'h0);

        // 2: fill, overflow, drain
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h10 + i));
            chk_st("fill", i + 1, 1'b0, 1'b0);
        end
        push(8'hFF);
        chk_st("ovf", 8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pop_chk("drain", 8'(8'h10 + i));
        end
        chk_st("drained", 0, 1'b1, 1'b0);
        flush();
        chk_st("clr1", 0, 1'b0, 1'b0);

        // 3: pointer wrap
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        for (int i = 0; i < 5; i++) begin
            pop_chk("w5", 8'(8'h30 + i));
        end
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
        chk_st("wrapf", 8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pop_chk("wrap", 8'(8'hA0 + i));
        end
        chk_st("wrape", 0, 1'b0, 1'b0);

        // 4: simultaneous read/write, full then empty
        for (int i = 0; i < 8; i++) push(8'(8'hB0 + i));
        check("sim.hd", 32'(dout1), 32'hB0);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 8'hC0;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("sim.pop", 32'(dout0), 32'hB0);
        chk_st("simf", 8, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            pop_chk("simd", 8'(8'hB0 + i));
        end
        pop_chk("tail", 8'hC0);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 8'hD5;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_st("sime", 1, 1'b0, 1'b1);
        check("sime.hold", 32'(dout0), 32'hC0);
        pop_chk("sime", 8'hD5);
        chk_st("sime2", 0, 1'b0, 1'b1);

        // 5: flush with stored words and errors
        flush();
        chk_st("clr2", 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push(8'(8'hE0 + i));
        push(8'h77);
        for (int i = 0; i < 4; i++) begin
            pop_chk("pf", 8'(8'hE0 + i));
        end
        chk_st("pre.clr", 4, 1'b1, 1'b0);
        clr     = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 8'h66;
        tick();
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_st("clr3", 0, 1'b0, 1'b0);
        check("clr.hold", 32'(dout0), 32'hE3);
        push(8'h55);
        chk_st("p55", 1, 1'b0, 1'b0);
        pop_chk("p55", 8'h55);

        // 6: read latency
        push(8'h3C);
        check("lat.e", 32'(empty0), 32'h0);
        check("lat.f0", 32'(dout1), 32'h3C);
        tick();
        tick();
        check("lat.f2", 32'(dout1), 32'h3C);
        check("lat.s", 32'(dout0), 32'h55);
        pop_chk("lat", 8'h3C);
        chk_st("lat.end", 0, 1'b0, 1'b0);

        // read of an empty FIFO
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk_st("udf", 0, 1'b0, 1'b1);
        check("udf.hold", 32'(dout0), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
